toggle_rx: RTL and testbench
============================

TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on tog_in (legal values 2 to 4).
REQ-002 SHALL have parameter CNT_W, default 8, width of the accepted-toggle counter.
REQ-003 SHALL have parameter TIMEOUT, default 16, idle cycles allowed between accepted edges before loss is declared (legal values 2 or more).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port tog_in, input, 1 bit, asynchronous toggle line; each level change carries one event.
REQ-007 SHALL have port clr, input, 1 bit, synchronous clear of the counter and the state machine.
REQ-008 SHALL have port pulse_out, output, 1 bit, registered one-cycle pulse per accepted edge.
REQ-009 SHALL have port tog_cnt, output, CNT_W bits, accepted-edge count.
REQ-010 SHALL have port locked, output, 1 bit, high while state is LOCKED.
REQ-011 SHALL have port lost, output, 1 bit, high while state is LOST.

Function
REQ-012 SHALL detect an edge as a registered-previous versus synchronized-current mismatch, for both rising and falling edges.
REQ-013 SHALL, when tog_in changes before rising edge N, drive pulse_out high for exactly one cycle following rising edge N+SYNC_STAGES.
REQ-014 SHALL increment tog_cnt by 1 per accepted edge, saturating at all-ones with no wrap; pulse_out still fires while saturated.
REQ-015 SHALL implement FSM states IDLE, LOCKED and LOST.
REQ-016 SHALL transition IDLE→LOCKED, LOCKED→LOCKED and LOST→LOCKED on an accepted edge, and load the idle timer to 0 on each such edge.
REQ-017 SHALL increment the idle timer every LOCKED cycle without an edge, and enter LOST on the cycle the timer reaches TIMEOUT-1; the edge check takes priority over the timeout in the same cycle.
REQ-018 SHALL keep tog_cnt unchanged on loss; LOST→LOCKED resumes counting.
REQ-019 SHALL, on clr, zero tog_cnt and the timer and enter IDLE; clr wins over a simultaneous edge (edge not counted, pulse_out still asserted).
REQ-020 SHALL ignore edges during a priming window of SYNC_STAGES+1 cycles after reset release, so that a tog_in level held through reset produces no spurious pulse.

Reset
REQ-021 SHALL, on rst assertion, immediately force pulse_out=0, tog_cnt=0, locked=0, lost=0, all synchronizer flops to 0, the timer to 0, the priming counter to 0 and the state to IDLE.
REQ-022 SHALL treat reset asserted mid-operation as fully equivalent to power-on reset, with no retained count.

Configuration
REQ-023 SHALL, when TOGGLE_RX_GLITCH_EN is defined, accept an edge only when the new synchronized level is stable for 2 consecutive samples; this adds 1 cycle of latency (pulse after rising edge N+SYNC_STAGES+1) and silently drops single-cycle tog_in glitches.
REQ-024 SHALL, when TOGGLE_RX_GLITCH_EN is undefined, accept every synchronized level change with the latency of REQ-013.

Structure
REQ-025 SHALL place the state enum (IDLE, LOCKED, LOST) and the default constants for SYNC_STAGES, CNT_W and TIMEOUT in package toggle_pkg.
REQ-026 SHALL implement the synchronizer chain as sub-module toggle_sync, parameterized by depth and with asynchronous reset to 0.

Verification
REQ-027 SHALL cover single edge: reset, prime, toggle tog_in 0→1 before edge 10 → pulse_out high in cycle after edge 12 only, tog_cnt=1, locked=1.
REQ-028 SHALL cover timeout: one edge, then tog_in held for 20 cycles with TIMEOUT=16 → lost=1 exactly 15 cycles after the LOCKED entry, tog_cnt unchanged; the next toggle → locked=1, tog_cnt=2.
REQ-029 SHALL cover saturation: CNT_W=4 and 20 toggles spaced 3 cycles apart → tog_cnt stops at 15, 20 pulses seen.
REQ-030 SHALL cover clr collision: clr asserted on the same cycle as an accepted edge → tog_cnt=0, state IDLE, pulse_out still high one cycle.
REQ-031 SHALL cover reset: tog_in=1 held through reset release → no pulse; rst asserted mid-count (tog_cnt=5) → outputs 0 asynchronously, before the next clk edge.
REQ-032 SHALL cover glitch filter: with TOGGLE_RX_GLITCH_EN defined, a 1-cycle tog_in pulse → no pulse_out, tog_cnt=0; a 3-cycle level change → one pulse, 1 cycle later than REQ-027.

Source files
------------

// File: rtl/toggle_pkg.sv
// toggle_pkg: shared types and default parameter values for the toggle receiver.
//   rx_state_e      : receiver state (IDLE, LOCKED, LOST)
//   SYNC_STAGES_DEF : default synchronizer depth
//   CNT_W_DEF       : default accepted-toggle counter width
//   TIMEOUT_DEF     : default idle cycles allowed between accepted edges
package toggle_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;
    localparam int TIMEOUT_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/toggle_rx_if.sv
// toggle_rx_if: groups the toggle receiver's event input, clear and status outputs.
//   tog_in    : asynchronous toggle line (one event per level change)
//   clr       : synchronous clear of counter and state machine
//   pulse_out : one-cycle pulse per accepted edge
//   tog_cnt   : accepted-edge count, CNT_W bits
//   locked    : receiver is tracking edges
//   lost      : edges stopped arriving for too long
// master = stimulus side, slave = receiver side.
interface toggle_rx_if #(
    parameter int CNT_W = 8
);
    logic             tog_in;
    logic             clr;
    logic             pulse_out;
    logic [CNT_W-1:0] tog_cnt;
    logic             locked;
    logic             lost;

    modport master (
        output tog_in,
        output clr,
        input  pulse_out,
        input  tog_cnt,
        input  locked,
        input  lost
    );

    modport slave (
        input  tog_in,
        input  clr,
        output pulse_out,
        output tog_cnt,
        output locked,
        output lost
    );
endinterface

// File: rtl/toggle_sync.sv
// toggle_sync: multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, clears every stage to 0
//   d_in  : asynchronous input
//   q_out : synchronized output (last stage)
// DEPTH sets the number of flops in the chain (2 to 4).
module toggle_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);
    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[DEPTH-1];
endmodule

// File: rtl/toggle_rx.sv
// toggle_rx: receives events encoded as level changes on an asynchronous toggle
// line, emits a one-cycle pulse per event, counts events (saturating) and tracks
// whether events keep arriving.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   rx  : toggle_rx_if.slave (tog_in, clr in; pulse_out, tog_cnt, locked, lost out)
// Build option: define TOGGLE_RX_GLITCH_EN to require the new synchronized level to
// be seen on two consecutive samples before an edge is accepted (one extra cycle of
// latency, single-cycle glitches dropped).
//
// state  | meaning
// IDLE   | after reset/clr, no edge accepted yet
// LOCKED | edges arriving, idle timer running
// LOST   | no edge for TIMEOUT-1 cycles, count frozen until the next edge
import toggle_pkg::*;

module toggle_rx #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    toggle_rx_if.slave  rx
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
    // Timer value from which the next idle cycle reaches TIMEOUT-1.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

    logic             sync_lvl;
    logic             prev_q, prev_d;
    logic [PW-1:0]    prime_q, prime_d;
    rx_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             primed;
    logic             hit;
    logic             edge_acc;
`ifdef TOGGLE_RX_GLITCH_EN
    logic             lvl_d1_q, lvl_d1_d;
`endif

    toggle_sync #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (rx.tog_in),
        .q_out (sync_lvl)
    );

    // Edge detection and priming.
    always_comb begin
        primed  = (prime_q == PRIME_DONE);
        prime_d = primed ? prime_q : prime_q + 1'b1;
`ifdef TOGGLE_RX_GLITCH_EN
        lvl_d1_d = sync_lvl;
        hit      = (sync_lvl != prev_q) && (sync_lvl == lvl_d1_q);
        // Reference level only moves on an accepted change, so a glitch that
        // returns to the old level never registers. During priming it simply
        // follows the synchronizer so a level held through reset is absorbed.
        prev_d   = (!primed || hit) ? sync_lvl : prev_q;
`else
        hit      = (sync_lvl != prev_q);
        prev_d   = sync_lvl;
`endif
        edge_acc = primed && hit;
    end

    // Next-state, timer and counter.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        pulse_d = edge_acc;
        if (rx.clr) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_d   = '0;
        end else if (edge_acc) begin
            state_d = LOCKED;
            timer_d = '0;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else if (state_q == LOCKED) begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TIMER_LAST) begin
                state_d = LOST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            prime_q <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            prime_q <= prime_d;
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef TOGGLE_RX_GLITCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d1_q <= 1'b0;
        end else begin
            lvl_d1_q <= lvl_d1_d;
        end
    end
`endif

    assign rx.pulse_out = pulse_q;
    assign rx.tog_cnt   = cnt_q;
    assign rx.locked    = (state_q == LOCKED);
    assign rx.lost      = (state_q == LOST);
endmodule

// File: tb/tb_toggle_rx.sv
module tb_toggle_rx;
    localparam int SYNC = 2;
`ifdef TOGGLE_RX_GLITCH_EN
    localparam int LAT = SYNC + 1;
    localparam int GAP = 2;
`else
    localparam int LAT = SYNC;
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   exp_q[$];
    int   sat_pulses = 0;

    toggle_rx_if #(.CNT_W(8)) dif ();
    toggle_rx_if #(.CNT_W(4)) sif ();

    toggle_rx #(.SYNC_STAGES(SYNC), .CNT_W(8), .TIMEOUT(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .rx  (dif)
    );

    toggle_rx #(.SYNC_STAGES(SYNC), .CNT_W(4), .TIMEOUT(16)) u_sat (
        .clk (clk),
        .rst (rst),
        .rx  (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: each pulse must land on the cycle predicted at drive time.
    always @(negedge clk) begin
        if (!rst && dif.pulse_out) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    n_fail++;
                    $display("FAIL pulse_timing: got cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sif.pulse_out) sat_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic toggle();
        dif.tog_in = ~dif.tog_in;
        exp_q.push_back(cyc + 1 + LAT);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pulse: %0d outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic lvl);
        @(negedge clk);
        rst = 1'b1;
        dif.tog_in = lvl;
        dif.clr = 1'b0;
        sif.tog_in = 1'b0;
        sif.clr = 1'b0;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [7:0] cnt,
                             input logic lk, input logic ls);
        n_run++;
        if (dif.tog_cnt !== cnt || dif.locked !== lk || dif.lost !== ls) begin
            n_fail++;
            $display("FAIL %s: cnt/locked/lost got %0d/%b/%b, expected %0d/%b/%b",
                     name, dif.tog_cnt, dif.locked, dif.lost, cnt, lk, ls);
        end
    endtask

    task automatic test_reset();
        dif.tog_in = 1'b0;
        dif.clr = 1'b0;
        sif.tog_in = 1'b0;
        sif.clr = 1'b0;
        #1;
        check_out("reset_in", 8'd0, 1'b0, 1'b0);
        n_run++;
        if (dif.pulse_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse: got %b, expected 0", dif.pulse_out);
        end
        do_reset(1'b0);
        idle(4);
        check_out("reset_after", 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_prime();
        // Level held high through reset release must not count as an edge.
        do_reset(1'b1);
        idle(12);
        check_out("prime_no_edge", 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_single_edge();
        do_reset(1'b0);
        idle(4);
        toggle();
        drain("single");
        check_out("single_edge", 8'd1, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int e;
        do_reset(1'b0);
        idle(4);
        e = cyc + 1 + LAT;
        toggle();
        while (cyc != e + 14) @(negedge clk);
        check_out("timeout_before", 8'd1, 1'b1, 1'b0);
        @(negedge clk);
        check_out("timeout_lost", 8'd1, 1'b0, 1'b1);
        idle(5);
        check_out("timeout_hold", 8'd1, 1'b0, 1'b1);
        toggle();
        drain("timeout");
        check_out("timeout_relock", 8'd2, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        idle(4);
        for (int i = 0; i < 6; i++) begin
            toggle();
            idle(GAP);
        end
        drain("b2b");
        check_out("b2b_count", 8'd6, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        idle(4);
        sat_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            sif.tog_in = ~sif.tog_in;
            idle(3);
        end
        idle(10);
        n_run++;
        if (sif.tog_cnt !== 4'd15 || sat_pulses !== 20) begin
            n_fail++;
            $display("FAIL saturation: cnt %0d pulses %0d, expected 15 and 20",
                     sif.tog_cnt, sat_pulses);
        end
    endtask

    task automatic test_clr_collision();
        int a;
        do_reset(1'b0);
        idle(4);
        toggle();
        drain("clr_pre");
        check_out("clr_pre", 8'd1, 1'b1, 1'b0);
        a = cyc + 1 + LAT;
        toggle();
        while (cyc != a - 1) @(negedge clk);
        dif.clr = 1'b1;
        @(negedge clk);
        dif.clr = 1'b0;
        n_run++;
        if (dif.pulse_out !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pulse: got %b, expected 1", dif.pulse_out);
        end
        check_out("clr_collision", 8'd0, 1'b0, 1'b0);
        drain("clr_post");
        check_out("clr_settled", 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        do_reset(1'b0);
        idle(4);
`ifdef TOGGLE_RX_GLITCH_EN
        dif.tog_in = 1'b1;
        @(negedge clk);
        dif.tog_in = 1'b0;
        idle(8);
        check_out("glitch_dropped", 8'd0, 1'b0, 1'b0);
        toggle();
        idle(3);
        drain("glitch_level");
        check_out("glitch_level", 8'd1, 1'b1, 1'b0);
`else
        toggle();
        @(negedge clk);
        toggle();
        drain("glitch_pair");
        check_out("glitch_pair", 8'd2, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset(1'b0);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            toggle();
            idle(3);
        end
        drain("mid_pre");
        toggle();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = dif.pulse_out;
        end
        n_run++;
        if (!seen || dif.tog_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL mid_setup: pulse %b cnt %0d, expected 1 and 5", seen, dif.tog_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_run++;
        if (dif.pulse_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_pulse: got %b, expected 0", dif.pulse_out);
        end
        check_out("mid_async", 8'd0, 1'b0, 1'b0);
        exp_q.delete();
        do_reset(1'b0);
        idle(6);
        check_out("mid_after", 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_prime();
        test_single_edge();
        test_timeout();
        test_back_to_back();
        test_saturation();
        test_clr_collision();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
